// File: rtl/flash_spi_master.sv
// rtl/flash_spi_master.sv - byte-wide mode-0 SPI master for the configuration flash.
// Optional per-byte chip-select framing (AUTOCS) is built when FLASH_SPI_AUTOCS_EN is defined.
module flash_spi_master #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic       CPLDCLK,
  input  logic       CRST,
  input  logic       WR,
  input  logic       REG,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic       FLASHCLK,
  output logic       FLASHMOSI,
  input  logic       FLASHMISO,
  output logic       FLASHCS_N
);

  localparam logic [7:0] HP_LOAD = 8'(CLKDIV - 1);

`ifdef FLASH_SPI_AUTOCS_EN
  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_CSSETUP, S_CSHOLD} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] hp_q, hp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rxbuf_q, rxbuf_d;
  logic       cs_q, cs_d;
  logic       ovr_q, ovr_d;
  logic       autocs;
  logic       hp_done;
  logic       unused_wdata;

`ifdef FLASH_SPI_AUTOCS_EN
  logic autocs_q, autocs_d;
  assign autocs = autocs_q;
`else
  assign autocs = 1'b0;
`endif

  // Bits 5:2 of a control write carry nothing; bit 1 only matters with AUTOCS built in.
  assign unused_wdata = ^WDATA[5:1];
  assign hp_done = (hp_q == 8'd0);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxbuf_d = rxbuf_q;
    cs_d    = cs_q;
    ovr_d   = ovr_q;
`ifdef FLASH_SPI_AUTOCS_EN
    autocs_d = autocs_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_LOW: begin
        if (hp_done) begin
          state_d = S_HIGH;
          hp_d    = HP_LOAD;
          rx_d    = {rx_q[6:0], FLASHMISO};
        end else begin
          hp_d = hp_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (!hp_done) begin
          hp_d = hp_q - 8'd1;
        end else if (bit_q != 3'd0) begin
          state_d = S_LOW;
          hp_d    = HP_LOAD;
          bit_d   = bit_q - 3'd1;
          tx_d    = {tx_q[6:0], 1'b0};
        end else if (autocs) begin
`ifdef FLASH_SPI_AUTOCS_EN
          state_d = S_CSHOLD;
          hp_d    = HP_LOAD;
`endif
        end else begin
          state_d = S_IDLE;
          rxbuf_d = rx_q;
        end
      end
`ifdef FLASH_SPI_AUTOCS_EN
      S_CSSETUP: begin
        if (hp_done) begin
          state_d = S_LOW;
          hp_d    = HP_LOAD;
        end else begin
          hp_d = hp_q - 8'd1;
        end
      end
      S_CSHOLD: begin
        // RXBUF is published as the frame closes so it lines up with BUSY falling.
        if (hp_done) begin
          state_d = S_IDLE;
          rxbuf_d = rx_q;
        end else begin
          hp_d = hp_q - 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (WR && REG) begin
      cs_d = WDATA[0];
`ifdef FLASH_SPI_AUTOCS_EN
      autocs_d = WDATA[1];
`endif
      if (WDATA[6]) ovr_d = 1'b0;
      if (WDATA[7]) begin
        state_d = S_IDLE;
        bit_d   = 3'd0;
        hp_d    = 8'd0;
        rxbuf_d = rxbuf_q;
      end
    end else if (WR) begin
      if (state_q == S_IDLE) begin
        tx_d    = WDATA;
        bit_d   = 3'd7;
        hp_d    = HP_LOAD;
        state_d = S_LOW;
`ifdef FLASH_SPI_AUTOCS_EN
        if (autocs) state_d = S_CSSETUP;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CPLDCLK or negedge CRST) begin
    if (!CRST) begin
      state_q <= S_IDLE;
      hp_q    <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      rxbuf_q <= 8'd0;
      cs_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef FLASH_SPI_AUTOCS_EN
      autocs_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxbuf_q <= rxbuf_d;
      cs_q    <= cs_d;
      ovr_q   <= ovr_d;
`ifdef FLASH_SPI_AUTOCS_EN
      autocs_q <= autocs_d;
`endif
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign FLASHCLK  = (state_q == S_HIGH);
  assign FLASHMOSI = ((state_q == S_LOW) || (state_q == S_HIGH)) & tx_q[7];
  assign FLASHCS_N = !(cs_q | (autocs & BUSY));
  assign RDATA     = REG ? {BUSY, ovr_q, 4'b0000, autocs, cs_q} : rxbuf_q;

endmodule

// File: tb/tb_flash_spi_master.sv
// tb/tb_flash_spi_master.sv - self-checking bench for flash_spi_master at CLKDIV=2 and CLKDIV=1.
// AUTOCS expectations follow FLASH_SPI_AUTOCS_EN when the bench is built.
module tb_flash_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wr[2], reg_s[2], miso[2];
  logic [7:0] wdata[2], rdata[2];
  logic       busy[2], sck[2], mosi[2], cs_n[2];

  flash_spi_master #(.CLKDIV(2)) u_dut0 (
    .CPLDCLK(clk), .CRST(rst_n), .WR(wr[0]), .REG(reg_s[0]), .WDATA(wdata[0]),
    .RDATA(rdata[0]), .BUSY(busy[0]), .FLASHCLK(sck[0]), .FLASHMOSI(mosi[0]),
    .FLASHMISO(miso[0]), .FLASHCS_N(cs_n[0])
  );

  flash_spi_master #(.CLKDIV(1)) u_dut1 (
    .CPLDCLK(clk), .CRST(rst_n), .WR(wr[1]), .REG(reg_s[1]), .WDATA(wdata[1]),
    .RDATA(rdata[1]), .BUSY(busy[1]), .FLASHCLK(sck[1]), .FLASHMOSI(mosi[1]),
    .FLASHMISO(miso[1]), .FLASHCS_N(cs_n[1])
  );

  // Flash model: presents the reply MSB first, advancing one bit after each SCK rise,
  // and records every MOSI bit seen on an SCK rise.
  int         rises[2];
  int         base[2];
  logic [7:0] mosi_hist[2];
  logic [7:0] miso_byte[2];

  for (genvar g = 0; g < 2; g++) begin : g_flash
    int k;
    assign k = rises[g] - base[g];
    assign miso[g] = (k >= 0 && k < 8) ? miso_byte[g][3'(7 - k)] : 1'b0;
    always @(posedge sck[g]) begin
      mosi_hist[g] = {mosi_hist[g][6:0], mosi[g]};
      rises[g] = rises[g] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_op(input int d, input logic r, input logic [7:0] v);
    wr[d] = 1'b1;
    reg_s[d] = r;
    wdata[d] = v;
    tick();
    wr[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic r, output logic [7:0] v);
    reg_s[d] = r;
    #1;
    v = rdata[d];
  endtask

  task automatic start_xfer(input int d, input logic [7:0] tx, input logic [7:0] mb);
    miso_byte[d] = mb;
    base[d] = rises[d];
    wr_op(d, 1'b0, tx);
  endtask

  task automatic wait_done(input int d, output int n, output int cs_low);
    n = 0;
    cs_low = 0;
    while (busy[d] && n < 1000) begin
      if (!cs_n[d]) cs_low++;
      n++;
      tick();
    end
  endtask

  typedef struct {
    int         d;
    logic [7:0] ctrl;
    logic [7:0] tx;
    logic [7:0] mb;
    int         exp_cycles;
    logic [7:0] exp_status;
    logic       exp_csn;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[4];
    logic [7:0] v;
    int         n, cs_low, bound;
    int         auto_on;

    tbl[0] = '{0, 8'h01, 8'hA5, 8'h3C, 32, 8'h01, 1'b0};
    tbl[1] = '{0, 8'h00, 8'h00, 8'hFF, 32, 8'h00, 1'b1};
    tbl[2] = '{1, 8'h01, 8'hFF, 8'h00, 16, 8'h01, 1'b0};
    tbl[3] = '{1, 8'h40, 8'h81, 8'h7E, 16, 8'h00, 1'b1};

`ifdef FLASH_SPI_AUTOCS_EN
    auto_on = 1;
`else
    auto_on = 0;
`endif

    for (int i = 0; i < 2; i++) begin
      wr[i] = 1'b0; reg_s[i] = 1'b0; wdata[i] = 8'h00;
      miso_byte[i] = 8'h00; base[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("reset_csn", cs_n[i], 1'b1);
      check("reset_sck", sck[i], 1'b0);
      check("reset_mosi", mosi[i], 1'b0);
      check("reset_busy", busy[i], 1'b0);
      rd(i, 1'b0, v); check("reset_rxbuf", v, 8'h00);
      rd(i, 1'b1, v); check("reset_status", v, 8'h00);
    end
    rst_n = 1'b1;
    tick();

    // Table of single transfers
    for (int i = 0; i < 4; i++) begin
      int d;
      d = tbl[i].d;
      wr_op(d, 1'b1, tbl[i].ctrl);
      check("tbl_csn", cs_n[d], tbl[i].exp_csn);
      rd(d, 1'b1, v); check("tbl_status", v, tbl[i].exp_status);
      start_xfer(d, tbl[i].tx, tbl[i].mb);
      check("tbl_busy_rise", busy[d], 1'b1);
      wait_done(d, n, cs_low);
      check("tbl_cycles", n, tbl[i].exp_cycles);
      check("tbl_rises", rises[d] - base[d], 8);
      check("tbl_mosi", mosi_hist[d], tbl[i].tx);
      rd(d, 1'b0, v); check("tbl_rxbuf", v, tbl[i].mb);
    end

    // Randomized transfers against the flash model
    for (int i = 0; i < 16; i++) begin
      int d;
      logic cs;
      logic [7:0] tx, mb;
      d = $urandom_range(0, 1);
      cs = 1'($urandom_range(0, 1));
      tx = 8'($urandom);
      mb = 8'($urandom);
      wr_op(d, 1'b1, {7'b0, cs});
      start_xfer(d, tx, mb);
      wait_done(d, n, cs_low);
      check("rnd_cycles", n, 16 * (d == 0 ? 2 : 1));
      check("rnd_cs_low", cs_low, cs ? n : 0);
      check("rnd_mosi", mosi_hist[d], tx);
      rd(d, 1'b0, v); check("rnd_rxbuf", v, mb);
      rd(d, 1'b1, v); check("rnd_status", v, {7'b0, cs});
    end

    // Overrun: second data write while busy is dropped and flagged
    wr_op(0, 1'b1, 8'h01);
    start_xfer(0, 8'h9F, 8'h5A);
    repeat (3) tick();
    wr_op(0, 1'b0, 8'h00);
    rd(0, 1'b1, v); check("ovr_status_busy", v, 8'hC1);
    wait_done(0, n, cs_low);
    check("ovr_rises", rises[0] - base[0], 8);
    check("ovr_mosi", mosi_hist[0], 8'h9F);
    rd(0, 1'b0, v); check("ovr_rxbuf", v, 8'h5A);
    rd(0, 1'b1, v); check("ovr_sticky", v, 8'h41);
    wr_op(0, 1'b1, 8'h41);
    rd(0, 1'b1, v); check("ovr_cleared", v, 8'h01);

    // Abort mid-transfer
    start_xfer(0, 8'hFF, 8'h00);
    repeat (8) tick();
    wr_op(0, 1'b1, 8'h80);
    check("abort_busy", busy[0], 1'b0);
    check("abort_sck", sck[0], 1'b0);
    check("abort_csn", cs_n[0], 1'b1);
    rd(0, 1'b0, v); check("abort_rxbuf", v, 8'h5A);
    rd(0, 1'b1, v); check("abort_status", v, 8'h00);
    start_xfer(0, 8'h3C, 8'hC3);
    wait_done(0, n, cs_low);
    check("post_abort_cycles", n, 32);
    check("post_abort_mosi", mosi_hist[0], 8'h3C);
    rd(0, 1'b0, v); check("post_abort_rxbuf", v, 8'hC3);

    // AUTOCS framing at CLKDIV=1 (bit ignored when not built in)
    wr_op(1, 1'b1, 8'h02);
    rd(1, 1'b1, v); check("auto_status", v, auto_on ? 8'h02 : 8'h00);
    check("auto_csn_idle", cs_n[1], 1'b1);
    start_xfer(1, 8'h06, 8'hA3);
    check("auto_csn_start", cs_n[1], auto_on ? 1'b0 : 1'b1);
    wait_done(1, n, cs_low);
    check("auto_cycles", n, auto_on ? 18 : 16);
    check("auto_cs_low", cs_low, auto_on ? 18 : 0);
    check("auto_csn_end", cs_n[1], 1'b1);
    check("auto_mosi", mosi_hist[1], 8'h06);
    rd(1, 1'b0, v); check("auto_rxbuf", v, 8'hA3);
    wr_op(1, 1'b1, 8'h00);

    // Back-to-back at CLKDIV=1: next write on the first cycle after BUSY falls
    start_xfer(1, 8'h05, 8'h11);
    wait_done(1, n, cs_low);
    check("b2b_first_cycles", n, 16);
    start_xfer(1, 8'h00, 8'hEE);
    check("b2b_accepted", busy[1], 1'b1);
    wait_done(1, n, cs_low);
    check("b2b_second_cycles", n, 16);
    check("b2b_mosi", mosi_hist[1], 8'h00);
    rd(1, 1'b0, v); check("b2b_rxbuf", v, 8'hEE);
    rd(1, 1'b1, v); check("b2b_no_ovr", v, 8'h00);

    // Asynchronous reset mid-transfer
    wr_op(0, 1'b1, 8'h01);
    start_xfer(0, 8'hAA, 8'h55);
    bound = 0;
    while ((rises[0] - base[0]) < 4 && bound < 200) begin
      bound++;
      tick();
    end
    check("rst_reach_bit3", (rises[0] - base[0]) >= 4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_csn", cs_n[0], 1'b1);
    check("rst_sck", sck[0], 1'b0);
    check("rst_busy", busy[0], 1'b0);
    check("rst_mosi", mosi[0], 1'b0);
    rd(0, 1'b0, v); check("rst_rxbuf", v, 8'h00);
    rd(0, 1'b1, v); check("rst_status", v, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
